ocp_arbiter2: RTL and testbench
===============================

// Module: ocp_arbiter2
// PURPOSE
//  Two-master round-robin arbiter sharing one OCP slave port, e.g. sim_control or memory, between CPU and a DMA/testbench master.
//  Forwards one transaction at a time, routes accept/response back to the granted master only.
//  Bounds read-response wait with a timeout that returns ERR, so a dead slave cannot hang the bus.
// PARAMETERS
//  TMO_W    8    width of response-timeout counter
//  TMO_CYC  255  cycles waited for read SResp before ERR is returned (1..2^TMO_W-1)
// PORTS
//  clk              in   1            clock, rising edge
//  rst              in   1            reset, asynchronous, active-high
//  i_M0_MAddr       in   ADDR_WIDTH   master 0 address
//  i_M0_MCmd        in   3            master 0 command (OCP_CMD_*)
//  i_M0_MData       in   DATA_WIDTH   master 0 write data
//  i_M0_MByteEn     in   BEN_WIDTH    master 0 byte enables
//  o_M0_SCmdAccept  out  1            command accepted, to master 0
//  o_M0_SData       out  DATA_WIDTH   read data, to master 0
//  o_M0_SResp       out  2            response (OCP_RESP_*), to master 0
//  i_M1_* / o_M1_*  --   as M0        master 1, identical set
//  o_MAddr          out  ADDR_WIDTH   to slave
//  o_MCmd           out  3            to slave
//  o_MData          out  DATA_WIDTH   to slave
//  o_MByteEn        out  BEN_WIDTH    to slave
//  i_SCmdAccept     in   1            from slave
//  i_SData          in   DATA_WIDTH   from slave
//  i_SResp          in   2            from slave
// BEHAVIOUR
//  - Masters hold MCmd/MAddr/MData/MByteEn stable until they see their SCmdAccept.
//  - States: IDLE, CMD (waiting for i_SCmdAccept), RESP (read waiting for i_SResp != NULL). Reset -> IDLE, last=1, timer=0.
//  - Reset state: all slave-side outputs 0 (o_MCmd=OCP_CMD_IDLE); all master-side outputs 0 (SResp=OCP_RESP_NULL).
//  - IDLE: request means MCmd != IDLE. One requester: grant it.
//    Both requesting: grant the master != last.
//    Grant and last are registered; go to CMD. Arbitration latency is 1 cycle.
//  - CMD: slave outputs = granted master's inputs (combinational mux).
//    o_Mg_SCmdAccept = i_SCmdAccept; other master's accept = 0.
//    On accept with WRITE: transaction done -> IDLE (posted write, no response forwarded).
//    On accept with READ and i_SResp != NULL in the same cycle: forward the response -> IDLE.
//    Otherwise -> RESP with timer cleared.
//    CMD has no timeout.
//  - RESP: o_MCmd = IDLE and other slave outputs 0. Timer increments each cycle.
//    i_SResp != NULL: o_Mg_SResp = i_SResp and o_Mg_SData = i_SData for that cycle -> IDLE.
//    timer == TMO_CYC-1 with no response: o_Mg_SResp = OCP_RESP_ERR, SData = 0 -> IDLE.
//    Any late response afterwards is ignored.
//  - Non-granted master always sees SCmdAccept=0 and SResp=NULL. Slave outputs outside CMD are 0.
//  - Each transaction is followed by one IDLE bubble before the next grant, which gives strict alternation under contention.
//  - Illegal MCmd values (not IDLE/READ/WRITE) are forwarded and treated as WRITE, i.e. they complete on accept.
//  - rst asserted mid-transaction: immediate return to the reset state. The slave sees MCmd drop to IDLE asynchronously.
//  - Timer saturates at TMO_CYC-1 and never wraps.
// STRUCTURE
//  - OCP_CMD_*/OCP_RESP_* come from ocp_const.vh; ADDR/DATA/BEN widths come from common.vh.
//  - State encodings are local to the module; no new shared constants.
//  - Single module, no sub-modules: grant, FSM, timer and muxes are all small.
// TESTING
//  1) M0 writes 0x000 <= 0x000F_FFF0, M1 idle: grant M0 one cycle after request; slave sees WRITE/0x000; M0 gets accept; M1 outputs stay 0.
//  2) M1 reads 0x004 (slave holds 0x8) -> o_M1_SResp=DVA, o_M1_SData=0x8 for one cycle; M0 sees NULL.
//  3) M0 and M1 both issue READ in the same cycle after reset -> M0 served first, M1 second (one IDLE bubble); repeat both -> M0 again, since last=M1.
//  4) Slave never responds to a read (TMO_CYC=16) -> o_Mg_SResp=ERR exactly 16 cycles after accept; FSM IDLE next; next request granted normally.
//  5) Zero-latency slave (accept and DVA in the same cycle) -> master sees accept and DVA together; no RESP state.
//  6) rst pulsed during RESP -> all outputs 0 immediately; after release a pending M1 request is granted first only if M0 is idle.

Source files
------------

// File: rtl/ocp_arbiter2_pkg.sv
// Shared OCP constants, bus widths and arbiter state encoding for ocp_arbiter2.
package ocp_arbiter2_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int BEN_WIDTH  = 4;

  localparam logic [2:0] OCP_CMD_IDLE  = 3'b000;
  localparam logic [2:0] OCP_CMD_WRITE = 3'b001;
  localparam logic [2:0] OCP_CMD_READ  = 3'b010;

  localparam logic [1:0] OCP_RESP_NULL = 2'b00;
  localparam logic [1:0] OCP_RESP_DVA  = 2'b01;
  localparam logic [1:0] OCP_RESP_ERR  = 2'b11;

  // IDLE arbitrates, CMD waits for the slave accept, RESP waits for read data.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2
  } arbState_e;

  // Any command other than IDLE counts as a request for the slave port.
  function automatic logic isRequest(input logic [2:0] cmd);
    return cmd != OCP_CMD_IDLE;
  endfunction

endpackage

// File: rtl/ocp_arbiter2.sv
// Two-master round-robin arbiter in front of one OCP slave port.
// One transaction is in flight at a time; reads that never get a response
// are terminated with ERR after TMO_CYC cycles so a dead slave cannot hang the bus.
module ocp_arbiter2
  import ocp_arbiter2_pkg::*;
#(
  parameter int TMO_W   = 8,
  parameter int TMO_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_M0_MAddr,
  input  logic [2:0]            i_M0_MCmd,
  input  logic [DATA_WIDTH-1:0] i_M0_MData,
  input  logic [BEN_WIDTH-1:0]  i_M0_MByteEn,
  output logic                  o_M0_SCmdAccept,
  output logic [DATA_WIDTH-1:0] o_M0_SData,
  output logic [1:0]            o_M0_SResp,
  input  logic [ADDR_WIDTH-1:0] i_M1_MAddr,
  input  logic [2:0]            i_M1_MCmd,
  input  logic [DATA_WIDTH-1:0] i_M1_MData,
  input  logic [BEN_WIDTH-1:0]  i_M1_MByteEn,
  output logic                  o_M1_SCmdAccept,
  output logic [DATA_WIDTH-1:0] o_M1_SData,
  output logic [1:0]            o_M1_SResp,
  output logic [ADDR_WIDTH-1:0] o_MAddr,
  output logic [2:0]            o_MCmd,
  output logic [DATA_WIDTH-1:0] o_MData,
  output logic [BEN_WIDTH-1:0]  o_MByteEn,
  input  logic                  i_SCmdAccept,
  input  logic [DATA_WIDTH-1:0] i_SData,
  input  logic [1:0]            i_SResp
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  arbState_e         state_q, state_d;
  logic              grant_q, grant_d;
  logic              lastGrant_q, lastGrant_d;
  logic [TMO_W-1:0]  timer_q, timer_d;

  logic                  req0, req1;
  logic [2:0]            selCmd;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [DATA_WIDTH-1:0] selData;
  logic [BEN_WIDTH-1:0]  selBen;
  logic                  grantAccept;
  logic [1:0]            grantResp;
  logic [DATA_WIDTH-1:0] grantData;

  assign req0    = isRequest(i_M0_MCmd);
  assign req1    = isRequest(i_M1_MCmd);
  assign selCmd  = grant_q ? i_M1_MCmd    : i_M0_MCmd;
  assign selAddr = grant_q ? i_M1_MAddr   : i_M0_MAddr;
  assign selData = grant_q ? i_M1_MData   : i_M0_MData;
  assign selBen  = grant_q ? i_M1_MByteEn : i_M0_MByteEn;

  // State, grant, round-robin history and response timer; reset parks the bus idle with M0 favoured next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      timer_q     <= timer_d;
    end
  end

  // Next-state logic plus the slave-side mux and the response routed to the granted master.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    timer_d     = timer_q;
    o_MCmd      = OCP_CMD_IDLE;
    o_MAddr     = '0;
    o_MData     = '0;
    o_MByteEn   = '0;
    grantAccept = 1'b0;
    grantResp   = OCP_RESP_NULL;
    grantData   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          grant_d     = (req0 && req1) ? ~lastGrant_q : req1;
          lastGrant_d = grant_d;
          state_d     = ST_CMD;
        end
      end

      ST_CMD: begin
        o_MCmd      = selCmd;
        o_MAddr     = selAddr;
        o_MData     = selData;
        o_MByteEn   = selBen;
        grantAccept = i_SCmdAccept;
        if (i_SCmdAccept) begin
          if (selCmd == OCP_CMD_READ) begin
            if (i_SResp != OCP_RESP_NULL) begin
              grantResp = i_SResp;
              grantData = i_SData;
              state_d   = ST_IDLE;
            end else begin
              timer_d = '0;
              state_d = ST_RESP;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_RESP: begin
        if (i_SResp != OCP_RESP_NULL) begin
          grantResp = i_SResp;
          grantData = i_SData;
          state_d   = ST_IDLE;
        end else if (timer_q == TMO_LAST) begin
          grantResp = OCP_RESP_ERR;
          state_d   = ST_IDLE;
        end else begin
          timer_d = timer_q + TMO_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_M0_SCmdAccept = grantAccept & ~grant_q;
  assign o_M0_SResp      = grant_q ? OCP_RESP_NULL : grantResp;
  assign o_M0_SData      = grant_q ? '0 : grantData;
  assign o_M1_SCmdAccept = grantAccept & grant_q;
  assign o_M1_SResp      = grant_q ? grantResp : OCP_RESP_NULL;
  assign o_M1_SData      = grant_q ? grantData : '0;

endmodule

// File: tb/tb_ocp_arbiter2.sv
// Directed bench for ocp_arbiter2: each cycle's expected outputs are queued when
// stimulus is driven and popped/compared at the following falling clock edge.
module tb_ocp_arbiter2;
  import ocp_arbiter2_pkg::*;

  localparam logic [2:0] CI = OCP_CMD_IDLE;
  localparam logic [2:0] CW = OCP_CMD_WRITE;
  localparam logic [2:0] CR = OCP_CMD_READ;
  localparam logic [1:0] RN = OCP_RESP_NULL;
  localparam logic [1:0] RD = OCP_RESP_DVA;
  localparam logic [1:0] RE = OCP_RESP_ERR;

  typedef struct packed {
    logic [2:0]  mCmd;
    logic [31:0] mAddr;
    logic [31:0] mData;
    logic [3:0]  mBen;
    logic        acc0;
    logic [1:0]  resp0;
    logic [31:0] data0;
    logic        acc1;
    logic [1:0]  resp1;
    logic [31:0] data1;
  } outs_t;

  typedef struct {
    string tag;
    outs_t exp;
  } sbEntry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m0Addr = '0, m0Data = '0, m1Addr = '0, m1Data = '0;
  logic [2:0]  m0Cmd = '0, m1Cmd = '0;
  logic [3:0]  m0Ben = 4'hF, m1Ben = 4'h3;
  logic        sAcc = 1'b0;
  logic [1:0]  sResp = '0;
  logic [31:0] sData = '0;

  logic        m0Acc, m1Acc;
  logic [1:0]  m0Resp, m1Resp;
  logic [31:0] m0RData, m1RData;
  logic [31:0] oAddr, oData;
  logic [2:0]  oCmd;
  logic [3:0]  oBen;

  sbEntry_t sb[$];
  int checks = 0;
  int failures = 0;

  ocp_arbiter2 #(.TMO_W(8), .TMO_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .i_M0_MAddr(m0Addr), .i_M0_MCmd(m0Cmd), .i_M0_MData(m0Data), .i_M0_MByteEn(m0Ben),
    .o_M0_SCmdAccept(m0Acc), .o_M0_SData(m0RData), .o_M0_SResp(m0Resp),
    .i_M1_MAddr(m1Addr), .i_M1_MCmd(m1Cmd), .i_M1_MData(m1Data), .i_M1_MByteEn(m1Ben),
    .o_M1_SCmdAccept(m1Acc), .o_M1_SData(m1RData), .o_M1_SResp(m1Resp),
    .o_MAddr(oAddr), .o_MCmd(oCmd), .o_MData(oData), .o_MByteEn(oBen),
    .i_SCmdAccept(sAcc), .i_SData(sData), .i_SResp(sResp)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  function automatic outs_t idl();
    return '0;
  endfunction

  // Expected outputs while master m is granted in the command phase.
  function automatic outs_t fwd(input bit m, input logic [2:0] cmd, input logic [31:0] addr,
                                input logic [31:0] data, input logic acc, input logic [1:0] resp,
                                input logic [31:0] rdata);
    outs_t o = '0;
    o.mCmd  = cmd;
    o.mAddr = addr;
    o.mData = data;
    o.mBen  = m ? 4'h3 : 4'hF;
    if (m) begin o.acc1 = acc; o.resp1 = resp; o.data1 = rdata; end
    else   begin o.acc0 = acc; o.resp0 = resp; o.data0 = rdata; end
    return o;
  endfunction

  // Expected outputs when only a response is returned to master m.
  function automatic outs_t rsp(input bit m, input logic [1:0] resp, input logic [31:0] rdata);
    outs_t o = '0;
    if (m) begin o.resp1 = resp; o.data1 = rdata; end
    else   begin o.resp0 = resp; o.data0 = rdata; end
    return o;
  endfunction

  task automatic applyStimulus(input logic [2:0] c0, input logic [31:0] a0, input logic [31:0] d0,
                               input logic [2:0] c1, input logic [31:0] a1, input logic [31:0] d1,
                               input logic sa, input logic [1:0] sr, input logic [31:0] sd);
    @(posedge clk);
    #1;
    m0Cmd = c0; m0Addr = a0; m0Data = d0;
    m1Cmd = c1; m1Addr = a1; m1Data = d1;
    sAcc = sa; sResp = sr; sData = sd;
  endtask

  task automatic expectOut(input string tag, input outs_t o);
    sbEntry_t e;
    e.tag = tag;
    e.exp = o;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input bit waitEdge);
    sbEntry_t e;
    outs_t obs;
    if (waitEdge) @(negedge clk);
    obs = {oCmd, oAddr, oData, oBen, m0Acc, m0Resp, m0RData, m1Acc, m1Resp, m1RData};
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        failures++;
        $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    // Reset held while M0 already requests: everything must stay zero.
    applyStimulus(CW, 32'h1, 32'h2, CR, 32'h3, 32'h4, 1'b1, RD, 32'h5);
    expectOut("reset_hold", idl()); checkOutput(1);
    applyStimulus(CI, 0, 0, CI, 0, 0, 1'b0, RN, 0); rst = 1'b0;
    expectOut("reset_release", idl()); checkOutput(1);

    // M0 posted write, one-cycle arbitration, one wait cycle before accept.
    applyStimulus(CW, 32'h000, 32'h000F_FFF0, CI, 0, 0, 1'b0, RN, 0);
    expectOut("wr_arb", idl()); checkOutput(1);
    applyStimulus(CW, 32'h000, 32'h000F_FFF0, CI, 0, 0, 1'b0, RN, 0);
    expectOut("wr_cmd_wait", fwd(0, CW, 32'h000, 32'h000F_FFF0, 1'b0, RN, 0)); checkOutput(1);
    applyStimulus(CW, 32'h000, 32'h000F_FFF0, CI, 0, 0, 1'b1, RN, 0);
    expectOut("wr_accept", fwd(0, CW, 32'h000, 32'h000F_FFF0, 1'b1, RN, 0)); checkOutput(1);
    applyStimulus(CI, 0, 0, CI, 0, 0, 1'b0, RN, 0);
    expectOut("wr_done", idl()); checkOutput(1);

    // M1 read with one-cycle response latency.
    applyStimulus(CI, 0, 0, CR, 32'h004, 32'hDEAD_0000, 1'b0, RN, 0);
    expectOut("rd1_arb", idl()); checkOutput(1);
    applyStimulus(CI, 0, 0, CR, 32'h004, 32'hDEAD_0000, 1'b1, RN, 0);
    expectOut("rd1_accept", fwd(1, CR, 32'h004, 32'hDEAD_0000, 1'b1, RN, 0)); checkOutput(1);
    applyStimulus(CI, 0, 0, CI, 0, 0, 1'b0, RN, 32'h77);
    expectOut("rd1_wait", idl()); checkOutput(1);
    applyStimulus(CI, 0, 0, CI, 0, 0, 1'b0, RD, 32'h8);
    expectOut("rd1_resp", rsp(1, RD, 32'h8)); checkOutput(1);
    applyStimulus(CI, 0, 0, CI, 0, 0, 1'b0, RN, 0);
    expectOut("rd1_done", idl()); checkOutput(1);

    // Fresh reset so the round-robin history starts with last=M1.
    applyStimulus(CI, 0, 0, CI, 0, 0, 1'b0, RN, 0); rst = 1'b1;
    expectOut("reset2_hold", idl()); checkOutput(1);
    applyStimulus(CI, 0, 0, CI, 0, 0, 1'b0, RN, 0); rst = 1'b0;
    expectOut("reset2_release", idl()); checkOutput(1);

    // Contention: M0 first, bubble, then M1 (zero-latency slave), then M0 again.
    applyStimulus(CR, 32'h10, 0, CR, 32'h14, 0, 1'b0, RN, 0);
    expectOut("rr_arb0", idl()); checkOutput(1);
    applyStimulus(CR, 32'h10, 0, CR, 32'h14, 0, 1'b1, RN, 0);
    expectOut("rr_m0_accept", fwd(0, CR, 32'h10, 0, 1'b1, RN, 0)); checkOutput(1);
    applyStimulus(CI, 0, 0, CR, 32'h14, 0, 1'b0, RD, 32'hA0);
    expectOut("rr_m0_resp", rsp(0, RD, 32'hA0)); checkOutput(1);
    applyStimulus(CI, 0, 0, CR, 32'h14, 0, 1'b0, RN, 0);
    expectOut("rr_bubble", idl()); checkOutput(1);
    applyStimulus(CI, 0, 0, CR, 32'h14, 0, 1'b1, RD, 32'hB0);
    expectOut("rr_m1_zero_lat", fwd(1, CR, 32'h14, 0, 1'b1, RD, 32'hB0)); checkOutput(1);
    applyStimulus(CR, 32'h18, 0, CR, 32'h1C, 0, 1'b0, RN, 0);
    expectOut("rr_arb1", idl()); checkOutput(1);
    applyStimulus(CR, 32'h18, 0, CR, 32'h1C, 0, 1'b1, RD, 32'hC0);
    expectOut("rr_m0_again", fwd(0, CR, 32'h18, 0, 1'b1, RD, 32'hC0)); checkOutput(1);
    applyStimulus(CI, 0, 0, CR, 32'h1C, 0, 1'b0, RN, 0);
    expectOut("rr_bubble2", idl()); checkOutput(1);
    applyStimulus(CI, 0, 0, CR, 32'h1C, 0, 1'b1, RD, 32'hD0);
    expectOut("rr_m1_again", fwd(1, CR, 32'h1C, 0, 1'b1, RD, 32'hD0)); checkOutput(1);
    applyStimulus(CI, 0, 0, CI, 0, 0, 1'b0, RN, 0);
    expectOut("rr_done", idl()); checkOutput(1);

    // Dead slave: ERR exactly 16 cycles after accept, late DVA ignored.
    applyStimulus(CR, 32'h20, 0, CI, 0, 0, 1'b0, RN, 0);
    expectOut("tmo_arb", idl()); checkOutput(1);
    applyStimulus(CR, 32'h20, 0, CI, 0, 0, 1'b1, RN, 0);
    expectOut("tmo_accept", fwd(0, CR, 32'h20, 0, 1'b1, RN, 0)); checkOutput(1);
    for (int k = 0; k < 15; k++) begin
      applyStimulus(CI, 0, 0, CI, 0, 0, 1'b0, RN, 32'h99);
      expectOut($sformatf("tmo_wait%0d", k), idl()); checkOutput(1);
    end
    applyStimulus(CI, 0, 0, CI, 0, 0, 1'b0, RN, 32'h99);
    expectOut("tmo_err", rsp(0, RE, 0)); checkOutput(1);
    applyStimulus(CI, 0, 0, CW, 32'h30, 32'h33, 1'b0, RD, 32'h55);
    expectOut("tmo_late_ignored", idl()); checkOutput(1);
    applyStimulus(CI, 0, 0, CW, 32'h30, 32'h33, 1'b1, RN, 0);
    expectOut("tmo_next_grant", fwd(1, CW, 32'h30, 32'h33, 1'b1, RN, 0)); checkOutput(1);

    // Illegal command completes on accept like a write.
    applyStimulus(3'b111, 32'h40, 32'h44, CI, 0, 0, 1'b0, RN, 0);
    expectOut("ill_arb", idl()); checkOutput(1);
    applyStimulus(3'b111, 32'h40, 32'h44, CI, 0, 0, 1'b1, RN, 0);
    expectOut("ill_accept", fwd(0, 3'b111, 32'h40, 32'h44, 1'b1, RN, 0)); checkOutput(1);
    applyStimulus(CI, 0, 0, CI, 0, 0, 1'b0, RD, 32'h11);
    expectOut("ill_no_resp_state", idl()); checkOutput(1);

    // Reset during RESP; afterwards a lone M1 request is granted.
    applyStimulus(CR, 32'h50, 0, CI, 0, 0, 1'b0, RN, 0);
    expectOut("rst_resp_arb", idl()); checkOutput(1);
    applyStimulus(CR, 32'h50, 0, CI, 0, 0, 1'b1, RN, 0);
    expectOut("rst_resp_accept", fwd(0, CR, 32'h50, 0, 1'b1, RN, 0)); checkOutput(1);
    applyStimulus(CI, 0, 0, CW, 32'h60, 32'h66, 1'b0, RN, 0);
    expectOut("rst_resp_wait", idl()); checkOutput(1);
    #1 rst = 1'b1; #1;
    expectOut("rst_resp_async", idl()); checkOutput(0);
    applyStimulus(CI, 0, 0, CW, 32'h60, 32'h66, 1'b0, RD, 32'h8); rst = 1'b0;
    expectOut("rst_resp_after", idl()); checkOutput(1);
    applyStimulus(CI, 0, 0, CW, 32'h60, 32'h66, 1'b1, RD, 32'h8);
    expectOut("rst_m1_granted", fwd(1, CW, 32'h60, 32'h66, 1'b1, RN, 0)); checkOutput(1);

    // Reset asserted mid-CMD: slave command must drop without a clock edge.
    applyStimulus(CW, 32'h70, 32'h77, CI, 0, 0, 1'b0, RN, 0);
    expectOut("rst_cmd_arb", idl()); checkOutput(1);
    applyStimulus(CW, 32'h70, 32'h77, CI, 0, 0, 1'b0, RN, 0);
    expectOut("rst_cmd_fwd", fwd(0, CW, 32'h70, 32'h77, 1'b0, RN, 0)); checkOutput(1);
    #1 rst = 1'b1; #1;
    expectOut("rst_cmd_async", idl()); checkOutput(0);
    applyStimulus(CI, 0, 0, CI, 0, 0, 1'b0, RN, 0); rst = 1'b0;
    expectOut("final_idle", idl()); checkOutput(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
